// File: rtl/ddma_job_sched.sv
// ddma_job_sched: round-robin dDMA job scheduler with descriptor check; define DDMA_SCHED_PRIO_EN to give channel 0 strict priority
module ddma_job_sched #(
  parameter int NUM_CH = 4,
  parameter int CH_W = 2,
  parameter int DESC_W = 97
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_req_valid,
  output logic [NUM_CH-1:0]        o_req_ready,
  input  logic [NUM_CH*DESC_W-1:0] i_req_desc,
  output logic                     o_tag_start_dDMA,
  input  logic                     i_tag_resp_dDMA,
  output logic [31:0]              o_addr_RAM,
  output logic [15:0]              o_len_RAM,
  output logic [31:0]              o_addr_RAM_AIPE,
  output logic [15:0]              o_len_RAM_AIPE,
  output logic                     o_dir,
  output logic                     o_done_valid,
  output logic [CH_W-1:0]          o_done_ch,
  output logic                     o_done_err,
  output logic                     o_busy,
  output logic [CH_W-1:0]          o_cur_ch
);
  typedef enum logic [1:0] {IDLE_S, ISSUE_S, BUSY_S, DONE_S} state_t;
  state_t state_q, state_d;
  logic [NUM_CH-1:0] slot_v_q, slot_v_d;
  logic [DESC_W-1:0] slot_q [NUM_CH];
  logic [DESC_W-1:0] slot_d [NUM_CH];
  logic [DESC_W-1:0] desc_q, desc_d;
  logic [CH_W-1:0] rr_q, rr_d, cur_q, cur_d, win, idx, rr_nxt;
  logic tag_q, tag_d, err_q, err_d, found, go, desc_ok;
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(rr_q) + i) % NUM_CH);
      if (!found && slot_v_q[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
`ifdef DDMA_SCHED_PRIO_EN
    if (slot_v_q[0]) win = '0;
`endif
  end
  assign go = (state_q == IDLE_S) && (|slot_v_q) && (i_tag_resp_dDMA == tag_q);
  // SRAM->AIPE lengths must be whole 4-word AIPE lines or the dDMA hangs
  assign desc_ok = desc_q[96] | ((desc_q[47:32] != '0) && (desc_q[33:32] == 2'b00));
  assign rr_nxt = (cur_q == CH_W'(NUM_CH - 1)) ? '0 : cur_q + 1'b1;
  always_comb begin
    state_d = state_q;
    slot_v_d = slot_v_q;
    slot_d = slot_q;
    desc_d = desc_q;
    rr_d = rr_q;
    cur_d = cur_q;
    tag_d = tag_q;
    err_d = err_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_req_valid[c] && !slot_v_q[c]) begin
        slot_v_d[c] = 1'b1;
        slot_d[c] = i_req_desc[c*DESC_W +: DESC_W];
      end
    end
    case (state_q)
      IDLE_S: if (go) begin
        desc_d = slot_q[win];
        cur_d = win;
        slot_v_d[win] = 1'b0;
        err_d = 1'b0;
        state_d = ISSUE_S;
      end
      ISSUE_S: begin
        tag_d = desc_ok ? ~tag_q : tag_q;
        err_d = ~desc_ok;
        state_d = desc_ok ? BUSY_S : DONE_S;
      end
      BUSY_S: state_d = (i_tag_resp_dDMA == tag_q) ? DONE_S : BUSY_S;
      default: begin
`ifdef DDMA_SCHED_PRIO_EN
        rr_d = (cur_q == '0) ? rr_q : rr_nxt;
`else
        rr_d = rr_nxt;
`endif
        state_d = IDLE_S;
      end
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE_S;
      slot_v_q <= '0;
      desc_q <= '0;
      rr_q <= '0;
      cur_q <= '0;
      tag_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_v_q <= slot_v_d;
      desc_q <= desc_d;
      rr_q <= rr_d;
      cur_q <= cur_d;
      tag_q <= tag_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge i_clk) slot_q <= slot_d;
  assign o_req_ready = ~slot_v_q;
  assign o_tag_start_dDMA = tag_q;
  assign o_addr_RAM = desc_q[31:0];
  assign o_len_RAM = desc_q[47:32];
  assign o_addr_RAM_AIPE = desc_q[79:48];
  assign o_len_RAM_AIPE = desc_q[95:80];
  assign o_dir = desc_q[96];
  assign o_done_valid = (state_q == DONE_S);
  assign o_done_ch = o_done_valid ? cur_q : '0;
  assign o_done_err = o_done_valid & err_q;
  assign o_busy = (state_q != IDLE_S);
  assign o_cur_ch = cur_q;
endmodule
